rfa_wb_arbiter: RTL and testbench

Register-file write-back arbiter for the compute unit. Shares the single VGPR/SGPR write port between the eight ALU issue queues (SIMD0-3, SIMF0-3) and the LSU return path. Grants are one-hot and registered. VALU queues are served round-robin; the LSU has fixed priority over them. An optional starvation guard lets an aged VALU request pre-empt the LSU.

---
 rtl/rfa_wb_arbiter_if.sv | 32 +++
 rtl/rfa_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_rfa_wb_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rfa_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rfa_wb_arbiter_if
//  Description : Request/grant bundle between the write-back requesters
//                (VALU issue queues, LSU return path) and rfa_wb_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rfa_wb_arbiter_if;
    logic [7:0]  valu_req;
    logic        lsu_req;
    logic [7:0]  valu_serviced;
    logic        lsu_serviced;
    logic [15:0] select_fu;

    // master: requester side; slave: arbiter side
    modport master (
        output valu_req,
        output lsu_req,
        input  valu_serviced,
        input  lsu_serviced,
        input  select_fu
    );

    modport slave (
        input  valu_req,
        input  lsu_req,
        output valu_serviced,
        output lsu_serviced,
        output select_fu
    );
endinterface
`default_nettype wire

// File: rtl/rfa_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rfa_wb_arbiter
//  Description : Register-file write-back port arbiter. Round-robin over the
//                eight VALU queues, fixed LSU priority, one-hot registered
//                grants. Optional starvation guard: RFA_STARVE_GUARD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rfa_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AGE_W        = 3
) (
    input  wire logic       clk,
    input  wire logic       rst,
    rfa_wb_arbiter_if.slave bus
);

    logic [7:0] r_valu_serviced;
    logic       r_lsu_serviced;
    logic [2:0] r_ptr;

    logic [7:0] w_elig;
    logic [7:0] w_valu_pick;
    logic [7:0] w_valu_grant;
    logic       w_lsu_grant;
    logic [2:0] w_grant_idx;

    // First set bit at or above ptr, wrapping 7->0; returns one-hot or zero.
    function automatic logic [7:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [7:0] grant;
        logic [2:0] idx;
        grant = '0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (req[idx] && (grant == '0)) begin
                grant[idx] = 1'b1;
            end
        end
        return grant;
    endfunction

    // A queue granted last cycle still shows the granted entry as valid.
    assign w_elig      = bus.valu_req & ~r_valu_serviced;
    assign w_valu_pick = rr_pick(w_elig, r_ptr);

`ifdef RFA_STARVE_GUARD_EN
    localparam logic [AGE_W-1:0] c_starve_limit = AGE_W'(STARVE_LIMIT);
    localparam logic [AGE_W-1:0] c_age_max      = '1;

    logic [AGE_W-1:0] r_age [8];
    logic [7:0]       w_starved;
    logic [7:0]       w_starved_pick;

    always_comb begin
        w_starved = '0;
        for (int i = 0; i < 8; i++) begin
            w_starved[i] = w_elig[i] && (r_age[i] >= c_starve_limit);
        end
    end

    assign w_starved_pick = rr_pick(w_starved, r_ptr);

    always_comb begin
        w_valu_grant = '0;
        w_lsu_grant  = 1'b0;
        if (|w_starved) begin
            w_valu_grant = w_starved_pick;
        end else if (bus.lsu_req) begin
            w_lsu_grant = 1'b1;
        end else begin
            w_valu_grant = w_valu_pick;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (!bus.valu_req[i] || w_valu_grant[i]) begin
                    r_age[i] <= '0;
                end else if (!r_valu_serviced[i] && (r_age[i] != c_age_max)) begin
                    r_age[i] <= r_age[i] + AGE_W'(1);
                end
            end
        end
    end
`else
    // Age parameters are accepted for a uniform instantiation but unused here.
    if ((STARVE_LIMIT < 1) || (AGE_W < 1)) begin : g_unused_cfg
    end

    always_comb begin
        w_valu_grant = '0;
        w_lsu_grant  = 1'b0;
        if (bus.lsu_req) begin
            w_lsu_grant = 1'b1;
        end else begin
            w_valu_grant = w_valu_pick;
        end
    end
`endif

    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (w_valu_grant[i]) begin
                w_grant_idx = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valu_serviced <= '0;
            r_lsu_serviced  <= 1'b0;
            r_ptr           <= '0;
        end else begin
            r_valu_serviced <= w_valu_grant;
            r_lsu_serviced  <= w_lsu_grant;
            if (|w_valu_grant) begin
                r_ptr <= w_grant_idx + 3'd1;
            end
        end
    end

    assign bus.valu_serviced = r_valu_serviced;
    assign bus.lsu_serviced  = r_lsu_serviced;
    assign bus.select_fu     = {7'b0, r_lsu_serviced, r_valu_serviced};

endmodule
`default_nettype wire

// File: tb/tb_rfa_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rfa_wb_arbiter
//  Description : Self-checking bench for rfa_wb_arbiter: directed vector
//                table, hand sequences and randomized traffic vs. a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rfa_wb_arbiter;

    localparam int STARVE_LIMIT = 4;
    localparam int AGE_W        = 3;
    localparam int AGE_MAX      = (1 << AGE_W) - 1;
`ifdef RFA_STARVE_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    rfa_wb_arbiter_if bus_if ();

    rfa_wb_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .AGE_W       (AGE_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: last winner (-1 idle, 0..7 VALU, 8 LSU), pointer, ages.
    int m_last;
    int m_ptr;
    int m_age [8];

    typedef struct {
        logic        rst;
        logic [7:0]  valu;
        logic        lsu;
        logic [15:0] exp_sel;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [7:0] v, input logic l,
                                input logic [15:0] e);
        vec_t x;
        x.rst = r; x.valu = v; x.lsu = l; x.exp_sel = e;
        vecs.push_back(x);
    endfunction

    function automatic int rr_choose(input logic [7:0] set);
        int best;
        int best_d;
        best   = -1;
        best_d = 99;
        for (int i = 0; i < 8; i++) begin
            if (set[i] && (((i - m_ptr + 8) % 8) < best_d)) begin
                best   = i;
                best_d = (i - m_ptr + 8) % 8;
            end
        end
        return best;
    endfunction

    function automatic void model_step(input logic r, input logic [7:0] v, input logic l);
        logic [7:0] elig;
        logic [7:0] starved;
        int win;
        if (r) begin
            m_last = -1;
            m_ptr  = 0;
            for (int i = 0; i < 8; i++) m_age[i] = 0;
            return;
        end
        elig    = '0;
        starved = '0;
        for (int i = 0; i < 8; i++) begin
            elig[i]    = v[i] && (m_last != i);
            starved[i] = GUARD_ON && elig[i] && (m_age[i] >= STARVE_LIMIT);
        end
        if (starved != 0)   win = rr_choose(starved);
        else if (l)         win = 8;
        else if (elig != 0) win = rr_choose(elig);
        else                win = -1;
        for (int i = 0; i < 8; i++) begin
            if (!v[i] || (win == i)) m_age[i] = 0;
            else if (m_last != i)    m_age[i] = (m_age[i] + 1 > AGE_MAX) ? AGE_MAX : m_age[i] + 1;
        end
        if ((win >= 0) && (win < 8)) m_ptr = (win + 1) % 8;
        m_last = win;
    endfunction

    function automatic logic [15:0] model_sel();
        logic [15:0] s;
        s = '0;
        if (m_last >= 0) s[m_last] = 1'b1;
        return s;
    endfunction

    task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle's inputs, advance past the edge, compare against the model.
    task automatic cycle(input logic r, input logic [7:0] v, input logic l);
        logic [15:0] es;
        rst = r;
        bus_if.valu_req = v;
        bus_if.lsu_req  = l;
        model_step(r, v, l);
        @(posedge clk);
        #1;
        es = model_sel();
        check("model", {bus_if.select_fu, bus_if.valu_serviced, bus_if.lsu_serviced},
              {es, es[7:0], es[8]});
    endtask

    task automatic check_sel(input string name, input logic [15:0] exp);
        check(name, {9'b0, bus_if.select_fu}, {9'b0, exp});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed table
        add(1, 8'h00, 0, 16'h0000);
        for (int i = 0; i < 9; i++) add(0, 8'hFF, 0, 16'h0001 << (i % 8));
        add(1, 8'h00, 0, 16'h0000);
        for (int i = 0; i < 6; i++) add(0, 8'h04, 0, (i % 2 == 0) ? 16'h0004 : 16'h0000);
        add(1, 8'h00, 0, 16'h0000);
        for (int i = 0; i < 4; i++) add(0, 8'h00, 1, 16'h0100);
        add(1, 8'h00, 0, 16'h0000);
        for (int i = 0; i < 4; i++) add(0, 8'h20, 1, 16'h0100);
        add(0, 8'h20, 1, GUARD_ON ? 16'h0020 : 16'h0100);
        add(1, 8'h00, 0, 16'h0000);
        add(0, 8'h0F, 0, 16'h0001);
        add(0, 8'h0F, 0, 16'h0002);
        add(1, 8'h0F, 0, 16'h0000);
        add(0, 8'h0F, 0, 16'h0001);

        rst = 1'b1;
        bus_if.valu_req = '0;
        bus_if.lsu_req  = 1'b0;
        model_step(1'b1, '0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_sel("reset_state", 16'h0000);

        foreach (vecs[k]) begin
            cycle(vecs[k].rst, vecs[k].valu, vecs[k].lsu);
            check_sel($sformatf("table[%0d]", k), vecs[k].exp_sel);
        end

        // Continuous LSU + queue 5: further starvation windows follow the model
        cycle(1, 8'h00, 0);
        repeat (30) cycle(0, 8'h20, 1);

        // Drop queue 3 on its age-3 cycle, re-raise: age must restart from 0
        cycle(1, 8'h00, 0);
        repeat (3) cycle(0, 8'h08, 1);
        cycle(0, 8'h00, 1);
        check_sel("drop_lsu", 16'h0100);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 8'h08, 1);
            check_sel($sformatf("drop_no_early[%0d]", i), 16'h0100);
        end
        cycle(0, 8'h08, 1);
        check_sel("drop_starve", GUARD_ON ? 16'h0008 : 16'h0100);

        // Randomized traffic, mixed load then heavy LSU with several starved queues
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 99) == 0, 8'($urandom), $urandom_range(0, 1) == 1);
        end
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 199) == 0, 8'($urandom) & 8'($urandom),
                  $urandom_range(0, 9) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
